ph_bl_sub: RTL
==============

Name: ph_bl_sub

Overview:
- Downstream consumer of the pulse-height ping-pong cache.
- When a completed PH frame is available, reads all FRAME_WORDS 16-bit words out of the cache read port and subtracts a per-word baseline held in an internal register file.
- Streams the corrected words out on an AXI-stream master, with backpressure, towards the PH packetiser.

Parameters:
- FRAME_WORDS, 128, words read per frame; cache addresses 0..FRAME_WORDS-1.
- RD_LAT, 1, cache read latency in cycles from ph_cache_enb/addr to ph_cache_data valid.
- OFIFO_DEPTH, 4, output FIFO depth; power of 2, minimum RD_LAT+3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ph_cache_valid  in  1  level; high while the cache is being filled
- ph_cache_enb  out  1  cache read enable
- ph_cache_raddr  out  8  cache read address
- ph_cache_data  in  16  cache read data, RD_LAT cycles after enb
- bl_wr_en  in  1  baseline register write strobe
- bl_wr_addr  in  8  baseline index
- bl_wr_data  in  16  baseline value
- m_axis_tdata  out  16  corrected PH word
- m_axis_tvalid  out  1  AXI-stream valid
- m_axis_tlast  out  1  high on word FRAME_WORDS-1
- m_axis_tready  in  1  AXI-stream ready
- busy  out  1  frame in progress
- frame_cnt  out  16  frames completed, wraps at 65535->0
- overrun_cnt  out  16  frames dropped, saturates at 65535

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE. Baseline registers are NOT reset; they hold their last written value.
- Trigger:
  - Start event is the falling edge of ph_cache_valid, detected from a registered copy (valid_d==1 && ph_cache_valid==0).
  - ph_cache_valid arriving high out of reset does not count as a start.
- State machine:
  - IDLE: on start event -> READ; rd_addr=0; busy=1.
  - READ: issue one read per cycle while (fifo_count + inflight) < OFIFO_DEPTH.
    - ph_cache_enb=1 and ph_cache_raddr=rd_addr on each issue cycle; rd_addr increments on issue.
    - After issuing address FRAME_WORDS-1 -> DRAIN.
  - DRAIN: wait until inflight==0 and the FIFO is empty, i.e. the last beat has been accepted (tvalid&&tready&&tlast). Then -> IDLE, frame_cnt+1, busy=0.
- Datapath:
  - The issued address travels down an RD_LAT-deep tag pipe alongside the read.
  - When the tag emerges, diff = ph_cache_data - baseline[tag], as a 17-bit subtraction.
  - diff is registered (1 cycle) and pushed into the FIFO with last=(tag==FRAME_WORDS-1).
  - Address-issue to FIFO-write latency is RD_LAT+1; FIFO-write to tvalid latency is 0 (first-word-fall-through).
- inflight counts reads issued but not yet written to the FIFO. The credit rule guarantees the FIFO never overflows, so FIFO writes are never blocked.
- AXI-stream rules:
  - tdata/tlast stay stable while tvalid && !tready.
  - Pop on tvalid && tready.
  - tready may toggle at any cycle; no combinational path from tready to tvalid.
- Baseline write while busy:
  - Takes effect on the next cycle.
  - A word whose subtraction happens in the same cycle as the write uses the old value.
- Start event while not IDLE: frame ignored, overrun_cnt+1 (saturating); the current frame continues unaffected.
- Start event in the same cycle as DRAIN->IDLE: counted as an overrun, not started.
- Reset mid-frame:
  - State -> IDLE; FIFO, inflight and tag pipe flushed; tvalid=0 next cycle.
  - Counters cleared; baselines retained.

Optional Feature:
- Macro PH_BL_SAT_EN.
- Defined: a negative diff (bit16 set) is clamped to 16'h0000.
- Undefined: tdata = diff[15:0], two's-complement wrap. Example: 5 - 7 -> 16'hFFFE.

Test Plan:
- Baseline all 0x0010, cache word i = 0x0100+i, tready=1, PH_BL_SAT_EN defined:
  - Pulse ph_cache_valid high then low -> 128 beats 0x00F0..0x016F.
  - tlast only on beat 127; first enb 1 cycle after the valid fall.
  - frame_cnt=1, busy falls after the last beat.
- Word 3 = 0x0005 with baseline[3]=0x0007:
  - Macro defined -> beat 3 = 0x0000.
  - Macro undefined -> beat 3 = 0xFFFE.
- tready random 30% duty:
  - Beat sequence identical to the tready=1 run; no drops or duplicates.
  - FIFO never exceeds OFIFO_DEPTH; tdata stable while stalled.
- Second valid falling edge at beat 50 of a frame:
  - Overrun_cnt=1; 128 beats of the first frame only; frame_cnt=1.
- Assert rst for 1 cycle at beat 64 with tready=1:
  - tvalid=0 the next cycle; counters 0.
  - A following trigger yields a full clean 128-beat frame using the pre-reset baselines.
- Write bl_wr_addr=100, data 0x0020 mid-frame, before word 100 is read:
  - Beat 100 uses 0x0020.
  - A write issued after word 100 has been subtracted leaves beat 100 unchanged.

Source files
------------

// File: rtl/ph_bl_sub.sv
// ph_bl_sub - pulse-height baseline subtractor.
//
// Waits for a completed PH frame in the ping-pong cache (falling edge of
// ph_cache_valid), reads FRAME_WORDS words through the cache read port,
// subtracts a per-word baseline from an internal register file and streams
// the corrected words out on an AXI-stream master.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ph_cache_valid      high while the cache is being filled; falling edge starts a frame
//   ph_cache_enb/raddr  cache read request (one word per cycle, credit limited)
//   ph_cache_data       cache read data, RD_LAT cycles after the request
//   bl_wr_en/addr/data  baseline register file write port (not reset)
//   m_axis_*            corrected word stream, tlast on word FRAME_WORDS-1
//   busy                frame in progress
//   frame_cnt           frames completed (wrapping)
//   overrun_cnt         frames dropped because a start arrived while busy (saturating)
//
// Build option:
//   PH_BL_SAT_EN  when defined, negative differences clamp to 16'h0000;
//                 otherwise the low 16 bits of the difference are output.

module ph_bl_sub #(
   parameter int unsigned FRAME_WORDS = 128,
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned OFIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ph_cache_valid,
   output logic        ph_cache_enb,
   output logic [7:0]  ph_cache_raddr,
   input  logic [15:0] ph_cache_data,
   input  logic        bl_wr_en,
   input  logic [7:0]  bl_wr_addr,
   input  logic [15:0] bl_wr_data,
   output logic [15:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic [15:0] overrun_cnt
);

   localparam int unsigned CW = $clog2(OFIFO_DEPTH) + 1;
   localparam int unsigned PW = $clog2(OFIFO_DEPTH);
   localparam int unsigned BW = $clog2(FRAME_WORDS);
   localparam logic [7:0]  LAST_ADDR = 8'(FRAME_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } state_t;

   state_t state, state_nxt;

   logic              valid_d;
   logic              start;
   logic [7:0]        rd_addr;
   logic              issue;
   logic              pop;
   logic              frame_done;
   logic [CW-1:0]     fifo_count;
   logic [CW-1:0]     inflight;
   logic [CW:0]       credit_used;

   logic [RD_LAT-1:0] tag_vld;
   logic [7:0]        tag_pipe [RD_LAT];
   logic [7:0]        tag_out;
   logic              tag_live;

   logic [15:0]       baseline [FRAME_WORDS];
   logic [15:0]       bl_rd;
   logic [15:0]       corr;

   logic              diff_vld;
   logic              diff_last;
   logic [15:0]       diff_q;

   logic [15:0]       fifo_data [OFIFO_DEPTH];
   logic              fifo_last [OFIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   // ------------------------------------------------------------------
   // Start detection: only a high->low transition seen through valid_d
   // counts, so valid already high when reset releases is not a start.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) valid_d <= 1'b0;
      else     valid_d <= ph_cache_valid;
   end

   assign start = valid_d & ~ph_cache_valid;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = READ;
         end
         READ: begin
            // Every issued read owns a FIFO slot until popped, so the FIFO
            // can never overflow and its write side never stalls.
            issue = (credit_used < (CW+1)'(OFIFO_DEPTH));
            if (issue && (rd_addr == LAST_ADDR)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (pop && m_axis_tlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign frame_done     = (state == DRAIN) && pop && m_axis_tlast;
   assign ph_cache_enb   = issue;
   assign ph_cache_raddr = rd_addr;
   assign busy           = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr <= '0;
      end else if ((state == IDLE) && start) begin
         rd_addr <= '0;
      end else if (issue) begin
         rd_addr <= rd_addr + 8'd1;
      end else if (frame_done) begin
         rd_addr <= '0;
      end
   end

   // ------------------------------------------------------------------
   // Tag pipe: carries the issued address alongside the cache read.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
      end else begin
         tag_vld[0]  <= issue;
         tag_pipe[0] <= rd_addr;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_vld[i]  <= tag_vld[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   assign tag_out  = tag_pipe[RD_LAT-1];
   assign tag_live = tag_vld[RD_LAT-1];

   // ------------------------------------------------------------------
   // Baseline register file (deliberately not reset). A write lands at
   // the clock edge, so a subtraction in the same cycle sees the old value.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (bl_wr_en && ({1'b0, bl_wr_addr} < 9'(FRAME_WORDS)))
         baseline[bl_wr_addr[BW-1:0]] <= bl_wr_data;
   end

   assign bl_rd = baseline[tag_out[BW-1:0]];

`ifdef PH_BL_SAT_EN
   logic [16:0] diff;
   always_comb begin
      diff = {1'b0, ph_cache_data} - {1'b0, bl_rd};
      corr = diff[16] ? '0 : diff[15:0];
   end
`else
   always_comb corr = ph_cache_data - bl_rd;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         diff_vld  <= 1'b0;
         diff_last <= 1'b0;
         diff_q    <= '0;
      end else begin
         diff_vld  <= tag_live;
         diff_last <= (tag_out == LAST_ADDR);
         diff_q    <= corr;
      end
   end

   // ------------------------------------------------------------------
   // Outstanding reads not yet written into the FIFO.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) inflight <= '0;
      else     inflight <= inflight + CW'(issue) - CW'(diff_vld);
   end

   // ------------------------------------------------------------------
   // Output FIFO, first-word-fall-through.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (diff_vld) begin
         fifo_data[wr_ptr] <= diff_q;
         fifo_last[wr_ptr] <= diff_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (diff_vld) wr_ptr <= wr_ptr + PW'(1);
         if (pop)      rd_ptr <= rd_ptr + PW'(1);
         fifo_count <= fifo_count + CW'(diff_vld) - CW'(pop);
      end
   end

   assign m_axis_tvalid = (fifo_count != '0);
   assign m_axis_tdata  = m_axis_tvalid ? fifo_data[rd_ptr] : '0;
   assign m_axis_tlast  = m_axis_tvalid & fifo_last[rd_ptr];
   assign pop           = m_axis_tvalid & m_axis_tready;

   // ------------------------------------------------------------------
   // Statistics counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt   <= '0;
         overrun_cnt <= '0;
      end else begin
         if (frame_done) frame_cnt <= frame_cnt + 16'd1;
         if (start && (state != IDLE) && (overrun_cnt != '1))
            overrun_cnt <= overrun_cnt + 16'd1;
      end
   end

endmodule
